// File: rtl/axis_step_monitor.sv
// rtl/axis_step_monitor.sv - step/direction receive monitor with homing, qualification and fault latch
module axis_step_monitor #(
    parameter int WIDTH        = 19,
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_PULSE    = 2,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CW,
    input  logic             CCW,
    input  logic             LS,
    input  logic             Home,
    input  logic [WIDTH-1:0] Limit,
    input  logic             Clear_Fault,
    output logic [WIDTH-1:0] Location,
    output logic             Dir,
    output logic             Step_Strobe,
    output logic             Moving,
    output logic             Homed,
    output logic             Fault,
    output logic [2:0]       Fault_Code
);

    typedef enum logic [1:0] {Q_LOW, Q_HIGH, Q_VOID} qual_t;
    typedef enum logic [1:0] {S_UNHOMED, S_HOMING, S_TRACKING, S_FAULTED} state_t;

    localparam int         IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [7:0] MIN_CNT = 8'(MIN_PULSE);

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_GLITCH   = 3'd2;
    localparam logic [2:0] FC_OVER     = 3'd3;
    localparam logic [2:0] FC_UNDER    = 3'd4;

    logic [SYNC_STAGES-1:0] cw_sync, ccw_sync, ls_sync, prime_sr;
    logic                   cw_s, ccw_s, ls_s, primed;

    qual_t      q_st     [2];
    qual_t      q_st_nxt [2];
    logic [7:0] q_cnt    [2];
    logic [7:0] q_cnt_nxt[2];
    logic [1:0] line_s, q_acc, q_glitch;
    logic       both_high, conflict_ev, glitch_ev;

    state_t            state, state_nxt;
    logic              cw_acc, ccw_acc, tracking_like;
    logic              over_ev, under_ev, fault_take, step_ok;
    logic [2:0]        new_code;
    logic [IDLE_W-1:0] idle_cnt;

    // Input synchronisers; prime_sr marks when the synchroniser outputs reflect post-reset samples
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cw_sync  <= '0;
            ccw_sync <= '0;
            ls_sync  <= '0;
            prime_sr <= '0;
        end else begin
            cw_sync  <= {cw_sync[SYNC_STAGES-2:0], CW};
            ccw_sync <= {ccw_sync[SYNC_STAGES-2:0], CCW};
            ls_sync  <= {ls_sync[SYNC_STAGES-2:0], LS};
            prime_sr <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign cw_s   = cw_sync[SYNC_STAGES-1];
    assign ccw_s  = ccw_sync[SYNC_STAGES-1];
    assign ls_s   = ls_sync[SYNC_STAGES-1];
    assign primed = prime_sr[SYNC_STAGES-1];
    assign line_s = {ccw_s, cw_s};

    // Pulse qualifiers (index 0 = CW, 1 = CCW); lines start VOID so a pulse already high at reset is never framed
    always_comb begin
        both_high   = cw_s & ccw_s;
        conflict_ev = primed && both_high && !(q_st[0] == Q_VOID && q_st[1] == Q_VOID);
        for (int i = 0; i < 2; i++) begin
            q_st_nxt[i]  = q_st[i];
            q_cnt_nxt[i] = q_cnt[i];
            q_acc[i]     = 1'b0;
            q_glitch[i]  = 1'b0;
            if (!primed) begin
                q_st_nxt[i]  = Q_VOID;
                q_cnt_nxt[i] = 8'd0;
            end else if (both_high) begin
                q_st_nxt[i]  = Q_VOID;
                q_cnt_nxt[i] = 8'd0;
            end else begin
                case (q_st[i])
                    Q_LOW: begin
                        if (line_s[i]) begin
                            q_st_nxt[i]  = Q_HIGH;
                            q_cnt_nxt[i] = 8'd1;
                        end
                    end
                    Q_HIGH: begin
                        if (line_s[i]) begin
                            q_cnt_nxt[i] = (q_cnt[i] >= MIN_CNT) ? q_cnt[i] : q_cnt[i] + 8'd1;
                        end else begin
                            q_st_nxt[i]  = Q_LOW;
                            q_cnt_nxt[i] = 8'd0;
                            if (q_cnt[i] >= MIN_CNT) q_acc[i] = 1'b1;
                            else                      q_glitch[i] = 1'b1;
                        end
                    end
                    Q_VOID: begin
                        if (!line_s[i]) q_st_nxt[i] = Q_LOW;
                    end
                    default: q_st_nxt[i] = Q_LOW;
                endcase
            end
        end
        glitch_ev = |q_glitch;
    end

    // Qualifier state registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                q_st[i]  <= Q_VOID;
                q_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                q_st[i]  <= q_st_nxt[i];
                q_cnt[i] <= q_cnt_nxt[i];
            end
        end
    end

    assign cw_acc        = q_acc[0];
    assign ccw_acc       = q_acc[1];
    assign tracking_like = (state == S_UNHOMED) || (state == S_TRACKING);
    assign over_ev       = tracking_like && cw_acc && (Location >= Limit);
    assign under_ev      = tracking_like && ccw_acc && (Location == '0);
    assign step_ok       = (cw_acc || ccw_acc) && (state != S_FAULTED);

    // Fault priority encode; a fault while already FAULTED only counts when it coincides with Clear_Fault
    always_comb begin
        new_code = FC_NONE;
        if      (conflict_ev) new_code = FC_CONFLICT;
        else if (glitch_ev)   new_code = FC_GLITCH;
        else if (over_ev)     new_code = FC_OVER;
        else if (under_ev)    new_code = FC_UNDER;
        fault_take = (new_code != FC_NONE) && ((state != S_FAULTED) || Clear_Fault);
    end

    // Top FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) state <= S_UNHOMED;
        else       state <= state_nxt;
    end

    // Top FSM next-state logic
    always_comb begin
        state_nxt = state;
        if (fault_take) begin
            state_nxt = S_FAULTED;
        end else begin
            case (state)
                S_UNHOMED:  if (Home) state_nxt = S_HOMING;
                S_TRACKING: if (Home) state_nxt = S_HOMING;
                S_HOMING: begin
                    if (ls_s)       state_nxt = S_TRACKING;
                    else if (!Home) state_nxt = S_UNHOMED;
                end
                S_FAULTED:  if (Clear_Fault) state_nxt = S_UNHOMED;
                default:    state_nxt = S_UNHOMED;
            endcase
        end
    end

    // Top FSM outputs derived from state
    always_comb begin
        Homed = (state == S_TRACKING);
        Fault = (state == S_FAULTED);
    end

    // Position, direction, strobe, fault code and idle tracking
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Location    <= '0;
            Dir         <= 1'b0;
            Step_Strobe <= 1'b0;
            Moving      <= 1'b0;
            idle_cnt    <= '0;
            Fault_Code  <= FC_NONE;
        end else begin
            Step_Strobe <= step_ok;
            if (step_ok) Dir <= cw_acc;

            if (state == S_HOMING || state_nxt == S_HOMING) begin
                Location <= '0;
            end else if (tracking_like) begin
                if (cw_acc && !over_ev)         Location <= Location + WIDTH'(1);
                else if (ccw_acc && !under_ev)  Location <= Location - WIDTH'(1);
            end

            if (fault_take)                            Fault_Code <= new_code;
            else if (state == S_FAULTED && Clear_Fault) Fault_Code <= FC_NONE;

            if (step_ok) begin
                Moving   <= 1'b1;
                idle_cnt <= IDLE_W'(1);
            end else if (Moving) begin
                if (idle_cnt == IDLE_W'(IDLE_TIMEOUT)) Moving <= 1'b0;
                else                                   idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_step_monitor.sv
// tb/tb_axis_step_monitor.sv - self-checking bench for axis_step_monitor
module tb_axis_step_monitor;
    localparam int WIDTH = 19;
    localparam int SS    = 2;
    localparam int MP    = 2;
    localparam int IT    = 20;

    localparam int MS_U = 0, MS_H = 1, MS_T = 2, MS_F = 3;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             CW = 1'b0, CCW = 1'b0, LS = 1'b0, Home = 1'b0, Clear_Fault = 1'b0;
    logic [WIDTH-1:0] Limit = '0;
    logic [WIDTH-1:0] Location;
    logic             Dir, Step_Strobe, Moving, Homed, Fault;
    logic [2:0]       Fault_Code;

    axis_step_monitor #(
        .WIDTH(WIDTH), .SYNC_STAGES(SS), .MIN_PULSE(MP), .IDLE_TIMEOUT(IT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .CW(CW), .CCW(CCW), .LS(LS), .Home(Home),
        .Limit(Limit), .Clear_Fault(Clear_Fault), .Location(Location), .Dir(Dir),
        .Step_Strobe(Step_Strobe), .Moving(Moving), .Homed(Homed), .Fault(Fault),
        .Fault_Code(Fault_Code)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_strobe = 0;
    always @(negedge Clock) if (Step_Strobe === 1'b1) n_strobe <= n_strobe + 1;

    int n_cmp = 0;
    int n_err = 0;

    int m_state = MS_U;
    int m_loc   = 0;
    bit m_dir   = 1'b0;
    int m_code  = 0;
    int m_strobes = 0;
    int m_limit = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".loc"},     32'(Location), 32'(m_loc));
        chk({tag, ".dir"},     32'(Dir), 32'(m_dir));
        chk({tag, ".fault"},   32'(Fault), 32'(m_state == MS_F));
        chk({tag, ".code"},    32'(Fault_Code), 32'(m_code));
        chk({tag, ".homed"},   32'(Homed), 32'(m_state == MS_T));
        chk({tag, ".strobes"}, 32'(n_strobe), 32'(m_strobes));
    endtask

    task automatic raise(input int c);
        if (m_state != MS_F) begin
            m_state = MS_F;
            m_code  = c;
        end
    endtask

    // Outcome of one complete pulse of w cycles on the chosen line
    task automatic model_pulse(input bit cw, input int w);
        if (w < MP) begin
            raise(2);
            return;
        end
        if (m_state == MS_F) return;
        m_strobes++;
        m_dir = cw;
        if (m_state == MS_H) return;
        if (cw) begin
            if (m_loc >= m_limit) raise(3);
            else                  m_loc++;
        end else begin
            if (m_loc == 0) raise(4);
            else            m_loc--;
        end
    endtask

    task automatic drive_pulse(input bit cw, input int w);
        @(negedge Clock);
        if (cw) CW = 1'b1; else CCW = 1'b1;
        repeat (w) @(negedge Clock);
        CW = 1'b0; CCW = 1'b0;
        repeat (SS + 4) @(negedge Clock);
        model_pulse(cw, w);
    endtask

    task automatic pulse_watch(input bit cw, input int w, output int lat, output int mov);
        int p;
        @(negedge Clock);
        if (cw) CW = 1'b1; else CCW = 1'b1;
        repeat (w) @(negedge Clock);
        CW = 1'b0; CCW = 1'b0;
        p   = cyc + 1;
        lat = -1;
        mov = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge Clock);
            if (Step_Strobe === 1'b1) begin
                lat = cyc - p;
                break;
            end
        end
        if (lat >= 0) begin
            while (Moving === 1'b1 && mov < 200) begin
                mov++;
                @(negedge Clock);
            end
        end
        model_pulse(cw, w);
    endtask

    task automatic do_clear();
        @(negedge Clock) Clear_Fault = 1'b1;
        @(negedge Clock) Clear_Fault = 1'b0;
        m_state = MS_U;
        m_code  = 0;
    endtask

    task automatic do_home();
        @(negedge Clock) Home = 1'b1;
        @(negedge Clock);
        m_state = MS_H;
        m_loc   = 0;
        LS = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge Clock);
            if (Homed === 1'b1) break;
        end
        Home = 1'b0;
        LS   = 1'b0;
        m_state = MS_T;
        repeat (SS + 2) @(negedge Clock);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, mov, p;
        bit d;
        int w;

        // Reset state
        repeat (3) @(negedge Clock);
        check_all("reset");
        chk("reset.strobe", 32'(Step_Strobe), 32'd0);
        chk("reset.moving", 32'(Moving), 32'd0);
        Reset = 1'b0;
        Limit = 19'd1000;
        m_limit = 1000;
        repeat (5) @(negedge Clock);

        // Homing: steps during HOMING strobe but do not move Location
        Home = 1'b1;
        @(negedge Clock);
        m_state = MS_H;
        check_all("homing_enter");
        for (int i = 0; i < 3; i++) drive_pulse(1'b0, 4);
        check_all("homing_steps");
        @(negedge Clock) LS = 1'b1;
        p = cyc + 1;
        @(negedge Clock);
        @(negedge Clock);
        chk("homed_early", 32'(Homed), 32'd0);
        @(negedge Clock);
        chk("homed_at_ls_plus1", 32'(Homed), 32'd1);
        chk("homed_edge", 32'(cyc - p), 32'(SS));
        Home = 1'b0;
        m_state = MS_T;
        @(negedge Clock) LS = 1'b0;
        repeat (SS + 2) @(negedge Clock);
        check_all("tracking_enter");

        // Tracking: 10 CW then 4 CCW, first pulse checked for latency
        pulse_watch(1'b1, 3, lat, mov);
        chk("cw_latency", 32'(lat), 32'(SS));
        for (int i = 0; i < 9; i++) drive_pulse(1'b1, 3);
        check_all("cw10");
        for (int i = 0; i < 4; i++) drive_pulse(1'b0, 3);
        check_all("ccw4");
        chk("loc_is_6", 32'(Location), 32'd6);

        // Glitch then ignored pulses then clear
        drive_pulse(1'b1, 1);
        check_all("glitch");
        drive_pulse(1'b1, 3);
        drive_pulse(1'b0, 3);
        check_all("faulted_ignore");
        do_clear();
        check_all("glitch_clear");

        // Conflict: both lines high for one cycle
        @(negedge Clock) begin CW = 1'b1; CCW = 1'b1; end
        @(negedge Clock) begin CW = 1'b0; CCW = 1'b0; end
        repeat (SS + 4) @(negedge Clock);
        raise(1);
        check_all("conflict");
        do_clear();
        check_all("conflict_clear");

        // Over-limit at Location == Limit
        Limit = 19'd5;
        m_limit = 5;
        drive_pulse(1'b0, 3);
        check_all("to_five");
        drive_pulse(1'b1, 3);
        check_all("over");
        do_clear();

        // Under-zero after homing
        do_home();
        check_all("rehome");
        drive_pulse(1'b0, 3);
        check_all("under");
        do_clear();
        check_all("under_clear");

        // Moving window after a single step
        pulse_watch(1'b1, 2, lat, mov);
        chk("moving_len", 32'(mov), 32'(IT));
        check_all("idle");

        // Randomised pulses against the reference model
        Limit = 19'd6;
        m_limit = 6;
        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 4));
            drive_pulse(d, w);
            check_all($sformatf("rand%0d", i));
            if (m_state == MS_F) do_clear();
        end

        // Reset in the middle of a pulse; the trailing edge must not step
        @(negedge Clock) CW = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        m_state = MS_U; m_loc = 0; m_dir = 1'b0; m_code = 0;
        check_all("reset_mid");
        chk("reset_mid.moving", 32'(Moving), 32'd0);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        CW = 1'b0;
        repeat (8) @(negedge Clock);
        check_all("reset_tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
